// File: rtl/lrf_pkg.sv
// ============================================================================
// Module      : lrf_pkg
// Description : Shared definitions for the line buffer: default parameter
//               values, the two-state controller encoding and helpers that
//               derive row-memory depth and counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lrf_pkg;

  // Default geometry of the line buffer
  localparam int LRF_PIXELS_PER_BEAT = 16;
  localparam int LRF_PIXEL_WIDTH     = 8;
  localparam int LRF_IMAGE_DIM       = 512;
  localparam int LRF_NUM_ROWS        = 3;

  // FILL   : collecting the first NUM_ROWS-1 rows, no output
  // STREAM : every accepted beat emits one vertical column
  typedef enum logic [0:0] {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } lrf_state_e;

  // Entries per row memory: one entry per beat of a row
  function automatic int lrf_buff_depth(input int image_dim, input int pixels_per_beat);
    return image_dim / pixels_per_beat;
  endfunction

  // Counter width that never collapses to zero bits
  function automatic int lrf_clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_buff_if.sv
// ============================================================================
// Module      : line_buff_if
// Description : Stream bundle of the line buffer. Carries the input beat
//               handshake, the output column handshake and the error flag.
//   Input side  : in_valid, in_ready, in_frame[DATA_WIDTH], in_last
//   Output side : out_valid, out_ready, out_frame[NUM_ROWS*DATA_WIDTH],
//                 out_last, out_eof
//   Status      : err
//   Modports    : slave  - the line buffer itself
//                 master - the environment driving beats and taking columns
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface line_buff_if
  import lrf_pkg::*;
#(
  parameter int DATA_WIDTH = LRF_PIXEL_WIDTH * LRF_PIXELS_PER_BEAT,
  parameter int NUM_ROWS   = LRF_NUM_ROWS
) ();

  logic                           in_valid;
  logic                           in_ready;
  logic [DATA_WIDTH-1:0]          in_frame;
  logic                           in_last;
  logic                           out_valid;
  logic                           out_ready;
  logic [NUM_ROWS*DATA_WIDTH-1:0] out_frame;
  logic                           out_last;
  logic                           out_eof;
  logic                           err;

  modport slave (
    input  in_valid, in_frame, in_last, out_ready,
    output in_ready, out_valid, out_frame, out_last, out_eof, err
  );

  modport master (
    output in_valid, in_frame, in_last, out_ready,
    input  in_ready, out_valid, out_frame, out_last, out_eof, err
  );

endinterface

`default_nettype wire

// File: rtl/row_ram.sv
// ============================================================================
// Module      : row_ram
// Description : One row of pixel beats. Single write port, single
//               asynchronous read port, storage without reset. A read of
//               the address being written in the same cycle returns the
//               old contents (the write lands on the clock edge).
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module row_ram #(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  wire              clk,
  input  wire              we,
  input  wire [ADDR_W-1:0] waddr,
  input  wire [WIDTH-1:0]  wdata,
  input  wire [ADDR_W-1:0] raddr,
  output wire [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/line_buff.sv
// ============================================================================
// Module      : line_buff
// Description : Sliding-window line buffer. Stores NUM_ROWS-1 previous rows
//               in a ring of row memories and, once enough rows are held,
//               emits for every accepted beat a vertical column of NUM_ROWS
//               beats (slice 0 = newest row). Output latency is one cycle.
//   clk     : clock, rising edge
//   aresetn : asynchronous active-low reset
//   bus     : line_buff_if.slave (input beats, output columns, err)
//   Optional: define LINE_BUFF_LAST_CHK_EN to flag (sticky err) any accepted
//             beat whose in_last disagrees with the column counter. Without
//             it in_last is ignored and err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buff
  import lrf_pkg::*;
#(
  parameter int PIXELS_PER_BEAT = LRF_PIXELS_PER_BEAT,
  parameter int PIXEL_WIDTH     = LRF_PIXEL_WIDTH,
  parameter int IMAGE_DIM       = LRF_IMAGE_DIM,
  parameter int NUM_ROWS        = LRF_NUM_ROWS,
  parameter int DATA_WIDTH      = PIXEL_WIDTH * PIXELS_PER_BEAT
) (
  input wire         clk,
  input wire         aresetn,
  line_buff_if.slave bus
);

  localparam int BUFF_DEPTH = lrf_buff_depth(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int NUM_MEMS   = NUM_ROWS - 1;
  localparam int COL_W      = lrf_clog2_min1(BUFF_DEPTH);
  localparam int ROW_W      = lrf_clog2_min1(IMAGE_DIM);
  localparam int SEL_W      = lrf_clog2_min1(NUM_MEMS);
  localparam int OUT_W      = NUM_ROWS * DATA_WIDTH;

  localparam logic [COL_W-1:0] c_col_last      = COL_W'(BUFF_DEPTH - 1);
  localparam logic [ROW_W-1:0] c_row_last      = ROW_W'(IMAGE_DIM - 1);
  localparam logic [ROW_W-1:0] c_row_fill_last = ROW_W'(NUM_ROWS - 2);
  localparam logic [SEL_W-1:0] c_sel_last      = SEL_W'(NUM_MEMS - 1);

  // --------------------------------------------------------------------------
  // State and position
  // --------------------------------------------------------------------------
  lrf_state_e       r_state;
  lrf_state_e       w_next_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [SEL_W-1:0] r_wr_sel;

  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_frame;
  logic             r_out_last;
  logic             r_out_eof;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_emit;
  logic             w_col_wrap;
  logic [OUT_W-1:0] w_column;
  logic [DATA_WIDTH-1:0] w_rd_data [NUM_MEMS];

  // Input may advance whenever the output register is free or being retired.
  // While filling nothing is produced, so an empty output register always
  // admits a beat. Reset holds the input stalled.
  always_comb begin
    w_in_ready = 1'b0;
    if (aresetn) begin
      w_in_ready = ~r_out_valid | bus.out_ready;
      if ((r_state == ST_FILL) && !r_out_valid) begin
        w_in_ready = 1'b1;
      end
    end
  end

  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_col_wrap = (r_col == c_col_last);

  // --------------------------------------------------------------------------
  // Controller: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Controller: next state and column-emit decision
  always_comb begin
    w_next_state = r_state;
    w_emit       = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_accept && w_col_wrap && (r_row == c_row_fill_last)) begin
          w_next_state = ST_STREAM;
        end
      end
      ST_STREAM: begin
        w_emit = w_accept;
        if (w_accept && w_col_wrap && (r_row == c_row_last)) begin
          w_next_state = ST_FILL;
        end
      end
      default: begin
        w_next_state = ST_FILL;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Position counters. wr_sel rotates every row so that the memory written
  // next always holds the oldest stored row.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_col    <= '0;
      r_row    <= '0;
      r_wr_sel <= '0;
    end else if (w_accept) begin
      if (w_col_wrap) begin
        r_col    <= '0;
        r_row    <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
        r_wr_sel <= (r_wr_sel == c_sel_last) ? '0 : r_wr_sel + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Row memory ring
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_MEMS; i++) begin : g_mem
      logic w_we;
      assign w_we = w_accept && (r_wr_sel == SEL_W'(i));

      row_ram #(
        .WIDTH  (DATA_WIDTH),
        .DEPTH  (BUFF_DEPTH),
        .ADDR_W (COL_W)
      ) u_row_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_col),
        .wdata (bus.in_frame),
        .raddr (r_col),
        .rdata (w_rd_data[i])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Column assembly. Row (r-k) lives in memory (wr_sel-k) mod NUM_MEMS; for
  // k = NUM_MEMS that is the memory being overwritten this cycle, whose old
  // contents are still visible on the read port.
  // --------------------------------------------------------------------------
  assign w_column[DATA_WIDTH-1:0] = bus.in_frame;

  generate
    for (genvar k = 1; k < NUM_ROWS; k++) begin : g_slice
      logic [SEL_W-1:0] w_src;
      assign w_src = (r_wr_sel >= SEL_W'(k)) ? (r_wr_sel - SEL_W'(k))
                                             : (r_wr_sel + SEL_W'(NUM_MEMS - k));
      assign w_column[k*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[w_src];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output register: loads on an emitted column, otherwise holds its content
  // and only drops valid once the column is taken.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_valid <= 1'b0;
      r_out_frame <= '0;
      r_out_last  <= 1'b0;
      r_out_eof   <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_frame <= w_column;
      r_out_last  <= w_col_wrap;
      r_out_eof   <= w_col_wrap && (r_row == c_row_last);
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_frame = r_out_frame;
  assign bus.out_last  = r_out_last;
  assign bus.out_eof   = r_out_eof;

  // --------------------------------------------------------------------------
  // in_last consistency check. Counters keep running on their own; the flag
  // only reports the disagreement and stays set until reset.
  // --------------------------------------------------------------------------
`ifdef LINE_BUFF_LAST_CHK_EN
  logic r_err;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_err <= 1'b0;
    end else if (w_accept && (bus.in_last != w_col_wrap)) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused_in_last;
  assign w_unused_in_last = bus.in_last;
  assign bus.err          = 1'b0;
`endif

endmodule

`default_nettype wire
